dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port DataMem between two requesters.
//   Port 0 is the core load/store stage, port 1 the debug/program loader.
//   Round-robin arbitration with a bounded burst: one port may hold the memory
//   for at most BURST_LEN consecutive grants while the other port is waiting.
//
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   pX_valid/ready               request handshake (ready is combinational)
//   pX_we/addr/wdata             request payload, held stable until ready
//   pX_rsp_valid/data/err        one-cycle response pulse, one cycle after grant
//   mem_write_enable/address/
//   mem_write_data               drive to DataMem (all zero with no grant)
//   mem_read_data                combinational read data from DataMem
module dmem_arbiter #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_data,
    output logic        p0_rsp_err,

    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_data,
    output logic        p1_rsp_err,

    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [3:0] BurstMax = 4'(BURST_LEN);
    localparam logic [3:0] CntSat   = 4'd15;

    logic        last_grant_q;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic        p0_rsp_valid_q, p1_rsp_valid_q;
    logic [31:0] p0_rsp_data_q, p1_rsp_data_q;
    logic        p0_rsp_err_q, p1_rsp_err_q;

    logic        gnt0, gnt1, any_gnt, keep_last;
    logic        p0_in_range, p1_in_range;

    assign p0_in_range = (p0_addr < DEPTH);
    assign p1_in_range = (p1_addr < DEPTH);

    // burst_cnt == 0 means no burst is in progress (after reset or an idle
    // cycle), so a contested cycle then goes to the port that did not have
    // the last grant. This is what gives port 0 the first contested cycle.
    assign keep_last = (burst_cnt_q != 4'd0) && (burst_cnt_q < BurstMax);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (p0_valid && p1_valid) begin
                if (keep_last) begin
                    gnt0 = ~last_grant_q;
                    gnt1 = last_grant_q;
                end else begin
                    gnt0 = last_grant_q;
                    gnt1 = ~last_grant_q;
                end
            end else begin
                gnt0 = p0_valid;
                gnt1 = p1_valid;
            end
        end
    end

    assign any_gnt  = gnt0 | gnt1;
    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    always_comb begin
        mem_write_enable = 1'b0;
        mem_address      = 32'd0;
        mem_write_data   = 32'd0;
        if (gnt0) begin
            mem_write_enable = p0_we & p0_in_range;
            mem_address      = p0_addr;
            mem_write_data   = p0_wdata;
        end else if (gnt1) begin
            mem_write_enable = p1_we & p1_in_range;
            mem_address      = p1_addr;
            mem_write_data   = p1_wdata;
        end
    end

    always_comb begin
        burst_cnt_d = 4'd0;
        if (any_gnt) begin
            if (gnt1 == last_grant_q) begin
                burst_cnt_d = (burst_cnt_q == CntSat) ? CntSat : burst_cnt_q + 4'd1;
            end else begin
                burst_cnt_d = 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q   <= 1'b1;
            burst_cnt_q    <= 4'd0;
            p0_rsp_valid_q <= 1'b0;
            p0_rsp_data_q  <= 32'd0;
            p0_rsp_err_q   <= 1'b0;
            p1_rsp_valid_q <= 1'b0;
            p1_rsp_data_q  <= 32'd0;
            p1_rsp_err_q   <= 1'b0;
        end else begin
            if (any_gnt) begin
                last_grant_q <= gnt1;
            end
            burst_cnt_q    <= burst_cnt_d;
            p0_rsp_valid_q <= gnt0;
            p0_rsp_data_q  <= (gnt0 && !p0_we && p0_in_range) ? mem_read_data : 32'd0;
            p0_rsp_err_q   <= gnt0 & ~p0_in_range;
            p1_rsp_valid_q <= gnt1;
            p1_rsp_data_q  <= (gnt1 && !p1_we && p1_in_range) ? mem_read_data : 32'd0;
            p1_rsp_err_q   <= gnt1 & ~p1_in_range;
        end
    end

    // A response pending when reset rises is dropped in that same cycle.
    assign p0_rsp_valid = p0_rsp_valid_q & ~reset;
    assign p0_rsp_data  = reset ? 32'd0 : p0_rsp_data_q;
    assign p0_rsp_err   = p0_rsp_err_q & ~reset;
    assign p1_rsp_valid = p1_rsp_valid_q & ~reset;
    assign p1_rsp_data  = reset ? 32'd0 : p1_rsp_data_q;
    assign p1_rsp_err   = p1_rsp_err_q & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int unsigned Depth = 256;
    localparam int unsigned Burst = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        p0_valid, p0_ready, p0_we, p0_rsp_valid, p0_rsp_err;
    logic [31:0] p0_addr, p0_wdata, p0_rsp_data;
    logic        p1_valid, p1_ready, p1_we, p1_rsp_valid, p1_rsp_err;
    logic [31:0] p1_addr, p1_wdata, p1_rsp_data;
    logic        mem_write_enable;
    logic [31:0] mem_address, mem_write_data, mem_read_data;

    always #5 clock = ~clock;

    dmem_arbiter #(
        .DEPTH    (Depth),
        .BURST_LEN(Burst)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .p0_valid        (p0_valid),
        .p0_ready        (p0_ready),
        .p0_we           (p0_we),
        .p0_addr         (p0_addr),
        .p0_wdata        (p0_wdata),
        .p0_rsp_valid    (p0_rsp_valid),
        .p0_rsp_data     (p0_rsp_data),
        .p0_rsp_err      (p0_rsp_err),
        .p1_valid        (p1_valid),
        .p1_ready        (p1_ready),
        .p1_we           (p1_we),
        .p1_addr         (p1_addr),
        .p1_wdata        (p1_wdata),
        .p1_rsp_valid    (p1_rsp_valid),
        .p1_rsp_data     (p1_rsp_data),
        .p1_rsp_err      (p1_rsp_err),
        .mem_write_enable(mem_write_enable),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data)
    );

    // DataMem: combinational read, write on posedge.
    logic [31:0] dmem [Depth];
    assign mem_read_data = (mem_address < Depth) ? dmem[mem_address[7:0]] : 32'd0;
    always @(posedge clock) begin
        if (mem_write_enable) dmem[mem_address[7:0]] <= mem_write_data;
    end

    // Reference state
    logic [31:0] ref_mem [Depth];
    logic [32:0] exp_q0 [$];
    logic [32:0] exp_q1 [$];
    logic        pend0 = 1'b0, pend1 = 1'b0;
    logic        m_last = 1'b1;
    int          m_cnt = 0;
    logic        obs_g0, obs_g1;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_p0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d;
    endtask

    // Push the expected response of a granted request and update the reference memory.
    task automatic push_exp(input logic port, input logic we, input logic [31:0] a,
                            input logic [31:0] d);
        logic [32:0] e;
        logic        in_range;
        in_range = (a < Depth);
        e = {~in_range, (!we && in_range) ? ref_mem[a[7:0]] : 32'd0};
        if (we && in_range) ref_mem[a[7:0]] = d;
        if (port) exp_q1.push_back(e);
        else      exp_q0.push_back(e);
    endtask

    // One clock cycle: inputs were set after the previous edge.
    task automatic tick();
        logic        mg0, mg1, exp_we;
        logic [32:0] e;
        #1;
        if (reset) begin
            check_eq("p0_rsp_valid_in_reset", {32'd0, p0_rsp_valid}, 33'd0);
            check_eq("p1_rsp_valid_in_reset", {32'd0, p1_rsp_valid}, 33'd0);
            if (pend0) void'(exp_q0.pop_front());
            if (pend1) void'(exp_q1.pop_front());
        end else begin
            check_eq("p0_rsp_valid", {32'd0, p0_rsp_valid}, {32'd0, pend0});
            check_eq("p1_rsp_valid", {32'd0, p1_rsp_valid}, {32'd0, pend1});
            if (pend0) begin
                e = exp_q0.pop_front();
                check_eq("p0_rsp", {p0_rsp_err, p0_rsp_data}, e);
            end
            if (pend1) begin
                e = exp_q1.pop_front();
                check_eq("p1_rsp", {p1_rsp_err, p1_rsp_data}, e);
            end
        end
        pend0 = 1'b0;
        pend1 = 1'b0;

        mg0 = 1'b0;
        mg1 = 1'b0;
        if (!reset) begin
            if (p0_valid && p1_valid) begin
                if (m_cnt != 0 && m_cnt < Burst) begin
                    mg0 = ~m_last; mg1 = m_last;
                end else begin
                    mg0 = m_last;  mg1 = ~m_last;
                end
            end else begin
                mg0 = p0_valid;
                mg1 = p1_valid;
            end
        end
        obs_g0 = p0_ready;
        obs_g1 = p1_ready;
        check_eq("p0_ready", {32'd0, p0_ready}, {32'd0, mg0});
        check_eq("p1_ready", {32'd0, p1_ready}, {32'd0, mg1});
        exp_we = mg0 ? (p0_we && p0_addr < Depth) : mg1 ? (p1_we && p1_addr < Depth) : 1'b0;
        check_eq("mem_write_enable", {32'd0, mem_write_enable}, {32'd0, exp_we});
        check_eq("mem_address", {1'b0, mem_address},
                 {1'b0, mg0 ? p0_addr : mg1 ? p1_addr : 32'd0});
        if (mg0) begin push_exp(1'b0, p0_we, p0_addr, p0_wdata); pend0 = 1'b1; end
        if (mg1) begin push_exp(1'b1, p1_we, p1_addr, p1_wdata); pend1 = 1'b1; end

        if (reset) begin
            m_last = 1'b1;
            m_cnt  = 0;
        end else if (mg0 || mg1) begin
            if (mg1 == m_last) m_cnt = (m_cnt == 15) ? 15 : m_cnt + 1;
            else               m_cnt = 1;
            m_last = mg1;
        end else begin
            m_cnt = 0;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int grants;
        int i0, i1, both;
        reset = 1'b1;
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clock);
        #1;
        // Ready must stay low during reset even with requests present
        set_p0(1'b1, 1'b1, 32'd3, 32'h1);
        set_p1(1'b1, 1'b1, 32'd4, 32'h2);
        tick();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        reset = 1'b0;

        // Write then read back on port 0
        set_p0(1'b1, 1'b1, 32'd5, 32'hDEADBEEF); tick();
        set_p0(1'b1, 1'b0, 32'd5, 32'd0);        tick();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);        tick();

        // Port 1 alone for 10 cycles: no forced yield
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            set_p1(1'b1, 1'b1, 32'(20 + i), 32'h1000 + 32'(i));
            tick();
            if (obs_g1) grants++;
        end
        check_eq("p1_solo_grants", 33'(grants), 33'd10);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0); tick();

        // Out-of-range write must not touch memory
        set_p1(1'b1, 1'b1, 32'd0, 32'h55);       tick();
        set_p1(1'b1, 1'b1, 32'd256, 32'h1234);   tick();
        set_p1(1'b1, 1'b0, 32'd0, 32'd0);        tick();
        set_p1(1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0); tick();
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);        tick();

        // Cross-port write then read of the same address
        set_p0(1'b1, 1'b1, 32'd7, 32'hA5A5A5A5); tick();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b1, 1'b0, 32'd7, 32'd0);        tick();
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);        tick();

        // Both ports contending: bursts of Burst grants alternate, p0 first
        i0 = 0; i1 = 0; both = 0;
        for (int c = 0; c < 16; c++) begin
            set_p0(1'b1, 1'b1, 32'(40 + i0), 32'hC000 + 32'(i0));
            set_p1(1'b1, 1'b0, 32'(20 + i1), 32'd0);
            tick();
            if (obs_g0 && obs_g1) both++;
            check_eq("burst_grant", {31'd0, obs_g1, obs_g0},
                     ((c / Burst) % 2 == 0) ? 33'd1 : 33'd2);
            if (obs_g0) i0++;
            if (obs_g1) i1++;
        end
        check_eq("never_both_ready", 33'(both), 33'd0);
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        set_p1(1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Reset right after a grant drops the response
        set_p0(1'b1, 1'b0, 32'd5, 32'd0); tick();
        set_p0(1'b0, 1'b0, 32'd0, 32'd0);
        reset = 1'b1; tick();
        tick();
        reset = 1'b0;
        set_p0(1'b1, 1'b0, 32'd7, 32'd0);
        set_p1(1'b1, 1'b0, 32'd5, 32'd0);
        tick();
        check_eq("post_reset_first_grant", {31'd0, obs_g1, obs_g0}, 33'd1);
        set_p0(1'b0, 1'b0, 32'd0, 32'd0); tick();
        set_p1(1'b0, 1'b0, 32'd0, 32'd0); tick();
        tick();

        check_eq("q0_drained", 33'(exp_q0.size()), 33'd0);
        check_eq("q1_drained", 33'(exp_q1.size()), 33'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
